// File: rtl/memory_bus_interface.sv
// rtl/memory_bus_interface.sv - serialises one byte-wide CPU access onto the multiplexed uio bus
//
// Purpose: accepts one core memory request at a time and drives it out as a
// low-address phase, an optional high-address phase and a data phase. The core
// is stalled through cpu_clk_enable until the access completes.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/rw/address/wdata   core request, held stable until cpu_clk_enable
//   cpu_clk_enable        core may advance this cycle
//   rdata, rdata_valid    read data and its one-cycle completion pulse
//   bus_error             one-cycle pulse on a timed-out completion
//   uio_in/out/oe         bidirectional pad data and output enable
//   bus_ale_l/ale_h       low/high address latch strobes
//   bus_rd_n/bus_wr_n     active-low read/write strobes
//   ext_wait              external device not ready, stretches the data phase
module memory_bus_interface #(
  parameter bit         PAGE_CACHE   = 1'b1,
  parameter int         WAIT_TIMEOUT = 15,
  parameter logic [7:0] TIMEOUT_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_rw,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        cpu_clk_enable,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        bus_error,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic        bus_ale_l,
  output logic        bus_ale_h,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  input  logic        ext_wait
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR_LO,
    S_ADR_HI,
    S_DATA,
    S_DONE
  } state_t;

  // Last wait-counter value before the access is forced to complete.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cache_q, cache_d;
  logic        cache_vld_q, cache_vld_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        page_hit;

  assign page_hit = PAGE_CACHE && cache_vld_q && (cache_q == addr_q[15:8]);

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_address;
          wdata_d = req_wdata;
          state_d = S_ADR_LO;
        end
      end
      S_ADR_LO: begin
        state_d = page_hit ? S_DATA : S_ADR_HI;
      end
      S_ADR_HI: begin
        cache_d     = addr_q[15:8];
        cache_vld_d = 1'b1;
        state_d     = S_DATA;
      end
      S_DATA: begin
        if (ext_wait) begin
          if (wait_cnt_q == WAIT_LAST) begin
            // Forced completion: the device never answered.
            err_d   = 1'b1;
            state_d = S_DONE;
            if (rw_q) rdata_d = TIMEOUT_DATA;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else begin
          if (rw_q) rdata_d = uio_in;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wait_cnt_d = 4'd0;
        err_d      = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      cache_q     <= 8'h00;
      cache_vld_q <= 1'b0;
      wait_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Bus outputs depend only on the state and the captured request, so the
  // pad direction can only flip at a state boundary.
  always_comb begin
    uio_out     = 8'h00;
    uio_oe      = 8'h00;
    bus_ale_l   = 1'b0;
    bus_ale_h   = 1'b0;
    bus_rd_n    = 1'b1;
    bus_wr_n    = 1'b1;
    rdata_valid = 1'b0;
    bus_error   = 1'b0;
    case (state_q)
      S_ADR_LO: begin
        uio_oe    = 8'hFF;
        uio_out   = addr_q[7:0];
        bus_ale_l = 1'b1;
      end
      S_ADR_HI: begin
        uio_oe    = 8'hFF;
        uio_out   = addr_q[15:8];
        bus_ale_h = 1'b1;
      end
      S_DATA: begin
        if (rw_q) begin
          bus_rd_n = 1'b0;
        end else begin
          uio_oe   = 8'hFF;
          uio_out  = wdata_q;
          bus_wr_n = 1'b0;
        end
      end
      S_DONE: begin
        rdata_valid = rw_q;
        bus_error   = err_q;
      end
      default: ;
    endcase
  end

  // Idle cycles without a request pass straight through to the core.
  assign cpu_clk_enable = rst_n && (((state_q == S_IDLE) && !req_valid) || (state_q == S_DONE));
  assign rdata          = rdata_q;

endmodule
